tx_mac: RTL and testbench
=========================

TX_MAC -- requirements
Module: tx_mac

Interface
REQ-001 SHALL have parameter MIN_IFG_WORDS, default 2, meaning the number of all-idle XGMII words inserted after every terminate word.
REQ-002 SHALL have port i_clk, input, 1 bit: clock.
REQ-003 SHALL have port i_reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port s00_axis_tdata, input, 64 bits: frame bytes, byte 0 in [7:0].
REQ-005 SHALL have port s00_axis_tkeep, input, 8 bits: byte-valid mask, LSB-contiguous.
REQ-006 SHALL have ports s00_axis_tvalid (input, 1), s00_axis_tready (output, 1) and s00_axis_tlast (input, 1): AXIS handshake and end of frame.
REQ-007 SHALL have port xgmii_txd, output, 64 bits: XGMII data, lane 0 in [7:0].
REQ-008 SHALL have port xgmii_txc, output, 8 bits: XGMII control flag per lane.
REQ-009 SHALL have port phy_tx_ready, input, 1 bit: PHY/gearbox consumes the current XGMII word this cycle.

Function
REQ-010 SHALL use states IDLE, PREAMBLE, DATA, PAD, TERM, IFG.
- IDLE->PREAMBLE on tvalid.
- PREAMBLE->DATA.
- DATA->PAD on tlast with fewer than 60 bytes accepted; otherwise DATA->TERM (or DATA->IFG when CRC and /T/ fit in the last word).
- PAD->TERM; TERM->IFG.
- IFG->IDLE after MIN_IFG_WORDS words.
REQ-011 SHALL emit idle (txd 0x0707070707070707, txc 0xFF) in IDLE and IFG.
REQ-012 SHALL emit start word txd 0xD5555555555555FB, txc 0x01 in PREAMBLE; a frame always starts in lane 0.
REQ-013 SHALL assert tready only in PREAMBLE and DATA while phy_tx_ready=1, and until tlast is accepted.
- Each accepted beat appears on xgmii_txd exactly 1 cycle later with txc=0x00 for data lanes.
REQ-014 SHALL stall when phy_tx_ready=0: state, counters, CRC and XGMII outputs held; tready=0; no beat lost or duplicated.
REQ-015 SHALL count accepted bytes, saturating at 60, and zero-pad frames shorter than 60 bytes to exactly 60 bytes before the FCS.
REQ-016 SHALL compute CRC32 over the payload plus pad bytes only, with a byte-enable mask equal to the emitted data-lane mask; the CRC is reset in IDLE.
REQ-017 SHALL transmit the FCS least-significant byte first: lane order o_crc[7:0], [15:8], [23:16], [31:24].
REQ-018 SHALL place the FCS and /T/ for a last word of k valid bytes (k=1..8) as follows; lanes after /T/ carry 0x07 with txc=1.
- k<=3: FCS in lanes k..k+3 and /T/ (0xFD) in lane k+4, all in the same word.
- k=4: FCS in lanes 4..7; /T/ in lane 0 of the next word.
- k>4: FCS split across the two words; /T/ in the lane after the last FCS byte.
REQ-019 SHALL treat a padded frame as k=4 on the 8th data word.
REQ-020 SHALL NOT require correct output for a non-last beat with tkeep!=0xFF or for tkeep=0x00; behaviour for these inputs is undefined.

Reset
REQ-021 SHALL, while i_reset=1, force state IDLE, tready=0, txd=0x0707070707070707, txc=0xFF, and clear the byte and IFG counters.
REQ-022 SHALL, on reset during a frame, abandon the frame with no /T/ and output idle from the next cycle.

Structure
REQ-023 SHALL take RS_START, RS_TERM, RS_IDLE and the preamble word constant from encoder_pkg.
- RS_IDLE and the preamble constant SHALL be added to encoder_pkg if absent.
- The state enum remains local to the module.
REQ-024 SHALL instantiate one crc32 sub-module with INPUT_WIDTH_BYTES=8 and REGISTER_OUTPUT=0.

Verification
REQ-025 Reset held 3 cycles -> txd=0x0707070707070707, txc=0xFF, tready=0 throughout.
REQ-026 64-byte frame, 8 beats with last tkeep=0xFF ->
- start word, then 8 data words;
- then FCS in lanes 0-3 with /T/ in lane 4 (txc=0xF0);
- then 2 idle words;
- FCS matches a software CRC32.
REQ-027 61-byte frame with last tkeep=0x1F ->
- FCS in lanes 5-7, then lane 0 of the next word;
- /T/ in lane 1, txc=0xFE.
REQ-028 14-byte frame ->
- 14 payload bytes plus 46 zero bytes;
- FCS over 60 bytes in lanes 4-7 of the 8th data word;
- /T/ in lane 0 of the following word.
REQ-029 phy_tx_ready random 20% low across a 100-byte frame -> the byte stream on consumed words equals that of the no-stall run.
REQ-030 Two back-to-back frames with tvalid always high -> exactly MIN_IFG_WORDS idle words between the /T/ word and the second start word.
REQ-031 Reset asserted mid-frame -> idle output on the next cycle, then a clean new frame is transmitted.

Source files
------------

// File: rtl/encoder_pkg.sv
// XGMII reconciliation-sublayer control characters and word constants
// shared by the transmit path.
package encoder_pkg;

    localparam logic [7:0] RS_START = 8'hFB;
    localparam logic [7:0] RS_TERM  = 8'hFD;
    localparam logic [7:0] RS_IDLE  = 8'h07;

    localparam logic [63:0] IDLE_WORD     = {8{RS_IDLE}};
    localparam logic [63:0] PREAMBLE_WORD = {8'hD5, {6{8'h55}}, RS_START};

    function automatic logic [3:0] keep_count(input logic [7:0] keep);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n += {3'b000, keep[i]};
        return n;
    endfunction

    // Lane pos (0..15) of the closing word pair: n data lanes, then FCS, /T/, idles.
    function automatic logic [8:0] fcs_lane(
        input logic [3:0]  pos,
        input logic [3:0]  n,
        input logic [63:0] d,
        input logic [31:0] fcs
    );
        logic [4:0] p;
        logic [4:0] m;
        logic [4:0] diff;
        p    = {1'b0, pos};
        m    = {1'b0, n};
        diff = p - m;
        if (p < m)
            return {1'b0, 8'(d >> {p[2:0], 3'b000})};
        else if (p < m + 5'd4)
            return {1'b0, 8'(fcs >> {diff[1:0], 3'b000})};
        else if (p == m + 5'd4)
            return {1'b1, RS_TERM};
        else
            return {1'b1, RS_IDLE};
    endfunction

endpackage

// File: rtl/crc32.sv
// Ethernet CRC32 (reflected 0xEDB88320) over a byte-enabled word;
// o_crc is the final inverted value including the current input when unregistered.
module crc32 #(
    parameter int INPUT_WIDTH_BYTES = 8,
    parameter bit REGISTER_OUTPUT   = 0
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_clear,
    input  logic                           i_en,
    input  logic [8*INPUT_WIDTH_BYTES-1:0] i_data,
    input  logic [INPUT_WIDTH_BYTES-1:0]   i_keep,
    output logic [31:0]                    o_crc
);

    localparam logic [31:0] POLY = 32'hEDB88320;

    logic [31:0] crc_q;
    logic [31:0] crc_next;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        crc_next = crc_q;
        for (int i = 0; i < INPUT_WIDTH_BYTES; i++)
            if (i_keep[i]) crc_next = crc_byte(crc_next, i_data[8*i +: 8]);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear)
            crc_q <= 32'hFFFF_FFFF;
        else if (i_en)
            crc_q <= crc_next;
    end

    assign o_crc = REGISTER_OUTPUT ? ~crc_q : ~crc_next;

endmodule

// File: rtl/tx_mac.sv
// AXI-Stream to 64-bit XGMII transmit MAC: start word, payload, zero pad
// to 60 bytes, FCS, /T/ and a fixed inter-frame gap.
import encoder_pkg::*;

module tx_mac #(
    parameter int MIN_IFG_WORDS = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [63:0] s00_axis_tdata,
    input  logic [7:0]  s00_axis_tkeep,
    input  logic        s00_axis_tvalid,
    output logic        s00_axis_tready,
    input  logic        s00_axis_tlast,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    input  logic        phy_tx_ready
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, DATA, PAD, TERM, IFG
    } state_t;

    state_t      state;
    logic [5:0]  byte_cnt;
    logic [15:0] ifg_cnt;
    logic [63:0] term_txd;
    logic [7:0]  term_txc;

    logic        accept;
    logic [3:0]  k;
    logic [6:0]  bc_sum;
    logic        full;
    logic        eighth;
    logic [63:0] dmask;
    logic [7:0]  crc_keep;
    logic [63:0] crc_data;
    logic        crc_en;
    logic [31:0] fcs;
    logic [3:0]  close_n;
    logic [63:0] close_d;
    logic [63:0] close_txd;
    logic [7:0]  close_txc;
    logic [63:0] next_txd;
    logic [7:0]  next_txc;

    assign s00_axis_tready = !i_reset && phy_tx_ready
                             && (state == PREAMBLE || state == DATA);
    assign accept = s00_axis_tvalid && s00_axis_tready;
    assign k      = keep_count(s00_axis_tkeep);
    assign bc_sum = {1'b0, byte_cnt} + {3'b000, k};
    assign full   = bc_sum >= 7'd60;
    assign eighth = byte_cnt == 6'd56;
    assign crc_en = phy_tx_ready && (accept || state == PAD);

    always_comb begin
        dmask = '0;
        for (int i = 0; i < 8; i++)
            if (s00_axis_tkeep[i]) dmask[8*i +: 8] = s00_axis_tdata[8*i +: 8];
    end

    // Padded frames always close as four bytes plus FCS on the 8th word.
    always_comb begin
        crc_keep = 8'hFF;
        crc_data = '0;
        close_n  = 4'd4;
        close_d  = '0;
        if (accept) begin
            crc_data = dmask;
            close_d  = dmask;
            if (!s00_axis_tlast || full) begin
                crc_keep = s00_axis_tkeep;
                close_n  = k;
            end else if (eighth) begin
                crc_keep = 8'h0F;
            end
        end else if (eighth) begin
            crc_keep = 8'h0F;
        end
    end

    always_comb begin
        close_txd = '0;
        close_txc = '0;
        next_txd  = '0;
        next_txc  = '0;
        for (int i = 0; i < 8; i++) begin
            {close_txc[i], close_txd[8*i +: 8]} =
                fcs_lane(4'(i), close_n, close_d, fcs);
            {next_txc[i], next_txd[8*i +: 8]} =
                fcs_lane(4'(i + 8), close_n, close_d, fcs);
        end
    end

    crc32 #(
        .INPUT_WIDTH_BYTES(8),
        .REGISTER_OUTPUT  (0)
    ) u_crc (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_clear(state == IDLE),
        .i_en   (crc_en),
        .i_data (crc_data),
        .i_keep (crc_keep),
        .o_crc  (fcs)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            xgmii_txd <= IDLE_WORD;
            xgmii_txc <= 8'hFF;
            byte_cnt  <= '0;
            ifg_cnt   <= '0;
            term_txd  <= IDLE_WORD;
            term_txc  <= 8'hFF;
        end else if (phy_tx_ready) begin
            unique case (state)
                IDLE: begin
                    byte_cnt  <= '0;
                    xgmii_txd <= IDLE_WORD;
                    xgmii_txc <= 8'hFF;
                    if (s00_axis_tvalid) begin
                        state     <= PREAMBLE;
                        xgmii_txd <= PREAMBLE_WORD;
                        xgmii_txc <= 8'h01;
                    end
                end
                PREAMBLE, DATA: begin
                    state <= DATA;
                    if (!accept) begin
                        xgmii_txd <= IDLE_WORD;
                        xgmii_txc <= 8'hFF;
                    end else if (!s00_axis_tlast) begin
                        xgmii_txd <= dmask;
                        xgmii_txc <= 8'h00;
                        byte_cnt  <= full ? 6'd60 : bc_sum[5:0];
                    end else if (full || eighth) begin
                        xgmii_txd <= close_txd;
                        xgmii_txc <= close_txc;
                        term_txd  <= next_txd;
                        term_txc  <= next_txc;
                        byte_cnt  <= 6'd60;
                        ifg_cnt   <= '0;
                        state     <= (full && k <= 4'd3) ? IFG : TERM;
                    end else begin
                        xgmii_txd <= dmask;
                        xgmii_txc <= 8'h00;
                        byte_cnt  <= byte_cnt + 6'd8;
                        state     <= PAD;
                    end
                end
                PAD: begin
                    if (eighth) begin
                        xgmii_txd <= close_txd;
                        xgmii_txc <= close_txc;
                        term_txd  <= next_txd;
                        term_txc  <= next_txc;
                        byte_cnt  <= 6'd60;
                        state     <= TERM;
                    end else begin
                        xgmii_txd <= '0;
                        xgmii_txc <= 8'h00;
                        byte_cnt  <= byte_cnt + 6'd8;
                    end
                end
                TERM: begin
                    xgmii_txd <= term_txd;
                    xgmii_txc <= term_txc;
                    ifg_cnt   <= '0;
                    state     <= IFG;
                end
                IFG: begin
                    xgmii_txd <= IDLE_WORD;
                    xgmii_txc <= 8'hFF;
                    ifg_cnt   <= ifg_cnt + 16'd1;
                    if (ifg_cnt + 16'd1 >= 16'(MIN_IFG_WORDS)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_mac.sv
// Directed and randomized frames checked against a byte-stream model of
// the XGMII framing (start, payload, pad, FCS, /T/, gap).
module tb_tx_mac;

    localparam int IFG = 2;

    typedef logic [71:0] word_t;
    typedef byte unsigned bq_t[$];

    localparam word_t IDLE72  = {8'hFF, {8{8'h07}}};

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [63:0] s00_axis_tdata = '0;
    logic [7:0]  s00_axis_tkeep = '0;
    logic        s00_axis_tvalid = 1'b0;
    logic        s00_axis_tready;
    logic        s00_axis_tlast = 1'b0;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        phy_tx_ready = 1'b1;

    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    bit    stall_en = 1'b0;
    word_t obs_q[$];
    word_t exp_q[$];

    tx_mac #(.MIN_IFG_WORDS(IFG)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .s00_axis_tdata (s00_axis_tdata),
        .s00_axis_tkeep (s00_axis_tkeep),
        .s00_axis_tvalid(s00_axis_tvalid),
        .s00_axis_tready(s00_axis_tready),
        .s00_axis_tlast (s00_axis_tlast),
        .xgmii_txd      (xgmii_txd),
        .xgmii_txc      (xgmii_txc),
        .phy_tx_ready   (phy_tx_ready)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        #1;
        phy_tx_ready = stall_en ? ($urandom_range(0, 99) >= 20) : 1'b1;
    end

    // Words the PHY actually consumes.
    always @(negedge i_clk)
        if (mon_en && phy_tx_ready) obs_q.push_back({xgmii_txc, xgmii_txd});

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_sw(input bq_t b);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c ^= {24'h0, b[i]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic model_frame(input bq_t p);
        logic [8:0]  lanes[$];
        bq_t         all;
        logic [31:0] crc;
        word_t       w;
        lanes.push_back({1'b1, 8'hFB});
        repeat (6) lanes.push_back({1'b0, 8'h55});
        lanes.push_back({1'b0, 8'hD5});
        all = p;
        while (all.size() < 60) all.push_back(8'h00);
        foreach (all[i]) lanes.push_back({1'b0, all[i]});
        crc = crc_sw(all);
        for (int i = 0; i < 4; i++) lanes.push_back({1'b0, crc[8*i +: 8]});
        lanes.push_back({1'b1, 8'hFD});
        while (lanes.size() % 8 != 0) lanes.push_back({1'b1, 8'h07});
        repeat (IFG * 8) lanes.push_back({1'b1, 8'h07});
        for (int x = 0; x < lanes.size() / 8; x++) begin
            for (int l = 0; l < 8; l++) begin
                w[64 + l]   = lanes[8*x + l][8];
                w[8*l +: 8] = lanes[8*x + l][7:0];
            end
            exp_q.push_back(w);
        end
    endtask

    task automatic gen(input int len, output bq_t q);
        q = {};
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    endtask

    task automatic send_frame(input bq_t p);
        int nb;
        nb = (p.size() + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            logic [63:0] d;
            logic [7:0]  kp;
            bit          acc;
            int          guard;
            d  = {$urandom, $urandom};
            kp = '0;
            for (int l = 0; l < 8; l++)
                if (b*8 + l < p.size()) begin
                    d[8*l +: 8] = p[b*8 + l];
                    kp[l] = 1'b1;
                end
            s00_axis_tdata  = d;
            s00_axis_tkeep  = kp;
            s00_axis_tlast  = (b == nb - 1);
            s00_axis_tvalid = 1'b1;
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 500) begin
                @(negedge i_clk);
                if (s00_axis_tready) acc = 1'b1;
                else if (!phy_tx_ready)
                    check("tready_stall", word_t'(s00_axis_tready), '0);
                @(posedge i_clk);
                #1;
                guard++;
            end
            check("handshake", word_t'(acc), word_t'(1));
        end
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
    endtask

    task automatic compare_stream(input string tag);
        int s;
        s = 0;
        while (s < obs_q.size() && obs_q[s] == IDLE72) s++;
        check({tag, " len"}, word_t'(obs_q.size() - s >= exp_q.size()), word_t'(1));
        foreach (exp_q[i])
            if (s + i < obs_q.size())
                check($sformatf("%s w%0d", tag, i), obs_q[s + i], exp_q[i]);
    endtask

    task automatic finish_run(input string tag);
        repeat (40) @(posedge i_clk);
        #1;
        stall_en = 1'b0;
        mon_en   = 1'b0;
        compare_stream(tag);
    endtask

    task automatic run_frame(input string tag, input bq_t p, input bit stall);
        obs_q.delete();
        exp_q.delete();
        model_frame(p);
        stall_en = stall;
        mon_en   = 1'b1;
        send_frame(p);
        finish_run(tag);
    endtask

    initial begin
        bq_t p;
        bq_t p2;

        repeat (3) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check("rst_out", {xgmii_txc, xgmii_txd}, IDLE72);
            check("rst_tready", word_t'(s00_axis_tready), '0);
        end
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        gen(64, p);  run_frame("f64", p, 0);
        gen(61, p);  run_frame("f61", p, 0);
        gen(14, p);  run_frame("f14", p, 0);
        gen(58, p);  run_frame("f58", p, 0);
        gen(65, p);  run_frame("f65", p, 0);
        gen(68, p);  run_frame("f68", p, 0);
        gen(100, p);
        run_frame("f100", p, 0);
        run_frame("f100_stall", p, 1);

        gen(20, p);
        gen(67, p2);
        obs_q.delete();
        exp_q.delete();
        model_frame(p);
        model_frame(p2);
        mon_en = 1'b1;
        send_frame(p);
        send_frame(p2);
        finish_run("b2b");

        for (int r = 0; r < 4; r++) begin
            gen($urandom_range(1, 130), p);
            run_frame($sformatf("rnd%0d", r), p, 1);
        end

        s00_axis_tdata  = {$urandom, $urandom};
        s00_axis_tkeep  = 8'hFF;
        s00_axis_tvalid = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        s00_axis_tvalid = 1'b0;
        @(negedge i_clk);
        check("midrst_tready", word_t'(s00_axis_tready), '0);
        @(posedge i_clk);
        @(negedge i_clk);
        check("midrst_out", {xgmii_txc, xgmii_txd}, IDLE72);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        gen(30, p);
        run_frame("post_rst", p, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
